// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: arbitrates two 9-bit value requesters, converts the granted value to BCD
// by sequential double-dabble, and scans the digits onto a shared BCD bus with active-low anodes.
`default_nettype none

module disp_scan_ctrl #(
  parameter int DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       req_a,
  input  logic [8:0] val_a,
  input  logic       sel_a,
  input  logic       req_b,
  input  logic [8:0] val_b,
  input  logic       sel_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [3:0] bcd,
  output logic [3:0] an,
  output logic       busy
);

  localparam int             CW       = $clog2(DIV);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DIV - 1);
  localparam logic [3:0]     ITER_MAX = 4'd8;
  localparam logic [3:0]     MINUS    = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [20:0]   sh_q, sh_d;
  logic [3:0]    it_q, it_d;
  logic          neg_lat_q, neg_lat_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic          prio_b_q, prio_b_d;
  logic          pend_q, pend_d;
  logic [11:0]   pend_dig_q, pend_dig_d;
  logic          pend_neg_q, pend_neg_d;
  logic [11:0]   dig_q, dig_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    bcd_q, bcd_d;

  logic          tick;
  logic          commit;
  logic [1:0]    nxt_slot;
  logic          gnt_b;
  logic [8:0]    g_val;
  logic          g_sel;
  logic [11:0]   adj;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Scanner: free-running prescaler and slot sequencer, independent of the converter
  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    cnt_d    = tick ? '0 : cnt_q + CW'(1);
    // slot_q resets to 3 so that the first tick always lands on slot 0
    case (slot_q)
      2'd0:    nxt_slot = 2'd1;
      2'd1:    nxt_slot = 2'd2;
      2'd2:    nxt_slot = neg_q ? 2'd3 : 2'd0;
      default: nxt_slot = 2'd0;
    endcase
    commit   = tick && (nxt_slot == 2'd0) && pend_q;
    dig_d    = commit ? pend_dig_q : dig_q;
    neg_d    = commit ? pend_neg_q : neg_q;
    slot_d   = slot_q;
    an_d     = an_q;
    bcd_d    = bcd_q;
    if (tick) begin
      slot_d = nxt_slot;
      an_d   = ~(4'b0001 << nxt_slot);
      case (nxt_slot)
        2'd0:    bcd_d = dig_d[3:0];
        2'd1:    bcd_d = dig_d[7:4];
        2'd2:    bcd_d = dig_d[11:8];
        default: bcd_d = MINUS;
      endcase
    end
  end

  // Converter FSM: grant, double-dabble, hand result to the pending registers
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    it_d       = it_q;
    neg_lat_d  = neg_lat_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    prio_b_d   = prio_b_q;
    pend_d     = pend_q;
    pend_dig_d = pend_dig_q;
    pend_neg_d = pend_neg_q;
    gnt_b      = req_b && (!req_a || prio_b_q);
    g_val      = gnt_b ? val_b : val_a;
    g_sel      = gnt_b ? sel_b : sel_a;
    adj        = {add3(sh_q[20:17]), add3(sh_q[16:13]), add3(sh_q[12:9])};

    case (state_q)
      S_IDLE: begin
        if (!pend_q && (req_a || req_b)) begin
          // signed mode: bit 8 low marks a negative value, magnitude is the low byte
          sh_d      = {12'd0, g_sel ? {1'b0, g_val[7:0]} : g_val};
          neg_lat_d = g_sel & ~g_val[8];
          ack_a_d   = ~gnt_b;
          ack_b_d   = gnt_b;
          prio_b_d  = ~gnt_b;
          it_d      = 4'd0;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        sh_d = {adj, sh_q[8:0]} << 1;
        it_d = it_q + 4'd1;
        if (it_q == ITER_MAX) state_d = S_DONE;
      end
      S_DONE: begin
        pend_dig_d = sh_q[20:9];
        pend_neg_d = neg_lat_q;
        pend_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) pend_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      it_q       <= '0;
      neg_lat_q  <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      prio_b_q   <= 1'b0;
      pend_q     <= 1'b0;
      pend_dig_q <= '0;
      pend_neg_q <= 1'b0;
      dig_q      <= '0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      slot_q     <= 2'd3;
      an_q       <= 4'b1111;
      bcd_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      it_q       <= it_d;
      neg_lat_q  <= neg_lat_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      prio_b_q   <= prio_b_d;
      pend_q     <= pend_d;
      pend_dig_q <= pend_dig_d;
      pend_neg_q <= pend_neg_d;
      dig_q      <= dig_d;
      neg_q      <= neg_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      an_q       <= an_d;
      bcd_q      <= bcd_d;
    end
  end

  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;
  assign an    = an_q;
  assign bcd   = bcd_q;
  assign busy  = (state_q != S_IDLE) | pend_q;

endmodule

`default_nettype wire
